// File: rtl/fifo_duth_ctl.sv
// rtl/fifo_duth_ctl.sv - FWFT circular-buffer FIFO with occupancy count, watermarks and sticky errors
// Pointers wrap by compare so any DEPTH >= 2 works; all status flags decode the count register.
module fifo_duth_ctl #(
  parameter int  DW       = 32,
  parameter int  DEPTH    = 4,
  parameter int  AF_LEVEL = DEPTH - 1,
  parameter int  AE_LEVEL = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          err_clr,
  input  logic [DW-1:0] write_data,
  input  logic          push,
  output logic          full,
  output logic          almost_full,
  output logic [DW-1:0] read_data,
  input  logic          pop,
  output logic          empty,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push_acc, pop_acc;

  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign read_data    = mem_q[head_q];

  always_comb begin
    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    pop_acc     = pop & ~empty & ~flush;
    push_acc    = push & (~full | pop) & ~flush;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    overflow_d  = (overflow_q & ~err_clr) | (push & full & ~pop & ~flush);
    underflow_d = (underflow_q & ~err_clr) | (pop & empty & ~flush);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop_acc) begin
        head_d = (head_q == PTR_LAST) ? '0 : head_q + PTR_ONE;
      end
      if (push_acc) begin
        tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + PTR_ONE;
      end
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[tail_q] <= write_data;
    end
  end

endmodule

// File: tb/tb_fifo_duth_ctl.sv
// tb/tb_fifo_duth_ctl.sv - scoreboard bench for fifo_duth_ctl at DEPTH=5 and DEPTH=2
// A queue-based model produces the expected state per edge; a monitor compares after each edge.
module tb_fifo_duth_ctl;

  localparam int DW = 8;

  typedef struct {
    int            cnt;
    logic [DW-1:0] head;
    bit            ov;
    bit            un;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  function automatic void check(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int D  = (g == 0) ? 5 : 2;
    localparam int AF = (g == 0) ? 4 : 2;
    localparam int AE = (g == 0) ? 1 : 0;
    localparam int CW = $clog2(D + 1);

    logic          rst = 1'b1, flush = 1'b0, err_clr = 1'b0, push = 1'b0, pop = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic [DW-1:0] read_data;
    logic          full, almost_full, empty, almost_empty, overflow, underflow;
    logic [CW-1:0] count;

    logic [DW-1:0] mq[$];
    exp_t          exp_q[$];
    bit            ov_m = 0, un_m = 0, done = 0;

    fifo_duth_ctl #(.DW(DW), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clk(clk), .rst(rst), .flush(flush), .err_clr(err_clr),
      .write_data(write_data), .push(push), .full(full), .almost_full(almost_full),
      .read_data(read_data), .pop(pop), .empty(empty), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
    );

    function automatic void chk(string n, longint a, longint e);
      check($sformatf("D%0d %s", D, n), a, e);
    endfunction

    task automatic reset_state_check(string tag);
      chk({tag, " count"}, count, 0);
      chk({tag, " empty"}, empty, 1);
      chk({tag, " full"}, full, 0);
      chk({tag, " almost_empty"}, almost_empty, 1);
      chk({tag, " almost_full"}, almost_full, 0);
      chk({tag, " overflow"}, overflow, 0);
      chk({tag, " underflow"}, underflow, 0);
    endtask

    task automatic step(bit p, bit q, bit f, bit ec, logic [DW-1:0] d);
      exp_t e;
      bit   was_full, was_empty;
      @(negedge clk);
      rst = 1'b0; push = p; pop = q; flush = f; err_clr = ec; write_data = d;
      was_full  = (mq.size() == D);
      was_empty = (mq.size() == 0);
      if (f) mq.delete();
      else begin
        if (q && !was_empty) void'(mq.pop_front());
        if (p && (!was_full || q)) mq.push_back(d);
      end
      ov_m = (ov_m && !ec) || (!f && p && was_full && !q);
      un_m = (un_m && !ec) || (!f && q && was_empty);
      e.cnt  = mq.size();
      e.head = (mq.size() != 0) ? mq[0] : '0;
      e.ov   = ov_m;
      e.un   = un_m;
      exp_q.push_back(e);
    endtask

    task automatic mid_reset();
      exp_t e;
      @(negedge clk);
      push = 1'($urandom); pop = 1'($urandom); flush = 1'b0; err_clr = 1'b0;
      #2 rst = 1'b1;
      #1 reset_state_check("async rst");
      mq.delete();
      ov_m = 0;
      un_m = 0;
      e.cnt = 0; e.head = '0; e.ov = 0; e.un = 0;
      exp_q.push_back(e);
    endtask

    initial forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("count", count, e.cnt);
        chk("full", full, e.cnt == D);
        chk("empty", empty, e.cnt == 0);
        chk("almost_full", almost_full, e.cnt >= AF);
        chk("almost_empty", almost_empty, e.cnt <= AE);
        chk("overflow", overflow, e.ov);
        chk("underflow", underflow, e.un);
        if (e.cnt != 0) chk("read_data", read_data, e.head);
      end
    end

    initial begin
      int r;
      repeat (2) @(negedge clk);
      #1 reset_state_check("reset");
      for (int i = 0; i < D; i++) step(1, 0, 0, 0, DW'(32'h11 + i));
      step(1, 0, 0, 0, 8'h66);
      for (int i = 0; i < D; i++) step(0, 1, 0, 0, DW'($urandom));
      for (int i = 0; i < D; i++) step(1, 0, 0, 0, DW'(32'h11 + i));
      step(1, 1, 0, 0, 8'h77);
      for (int i = 0; i < D; i++) step(0, 1, 0, 0, DW'($urandom));
      step(1, 1, 0, 0, 8'hA5);
      step(0, 0, 0, 1, DW'($urandom));
      step(0, 1, 0, 0, DW'($urandom));
      // Flush with push/pop high while overflow is already set.
      for (int i = 0; i < D; i++) step(1, 0, 0, 0, DW'($urandom));
      step(1, 0, 0, 0, 8'h66);
      for (int i = 0; i < D - 3; i++) step(0, 1, 0, 0, DW'($urandom));
      step(1, 1, 1, 0, DW'($urandom));
      for (int i = 0; i < 4 && i < D; i++) step(1, 0, 0, 0, DW'($urandom));
      mid_reset();
      repeat (2000) begin
        r = $urandom_range(0, 199);
        if (r == 0) mid_reset();
        else step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0, DW'($urandom));
      end
      @(negedge clk);
      rst = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
      done = 1;
    end
  end

  initial begin
    int cyc = 0;
    while (!(cfg[0].done && cfg[1].done) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    vectors++;
    if (!(cfg[0].done && cfg[1].done)) begin
      miscompares++;
      $display("FAIL timeout: got %0d cycles required completion under 20000", cyc);
    end
    repeat (2) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
